// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage request, resolve inputs and hazard controls
// between the pipeline datapath (master) and the hazard scoreboard (slave).
//   d_*               instruction currently in D (sources, destinations, class)
//   branch_taken_e    branch resolved taken in E
//   pcsrc_w           W writes the PC
//   stall_*/flush_*   pipeline register holds and clears, bubble_m for M
//   fwd_sel_e/hi_e    per-source forwarding select and 64-bit half select
//   mul_busy          multiply still occupying E
interface hazard_scoreboard_if #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 3
);
    logic                      d_valid;
    logic [NUM_SRC*REG_AW-1:0] d_src_addr;
    logic [NUM_SRC-1:0]        d_src_used;
    logic [REG_AW-1:0]         d_dst_addr;
    logic [REG_AW-1:0]         d_dst2_addr;
    logic                      d_dst_we;
    logic                      d_dst2_we;
    logic                      d_is_load;
    logic                      d_is_mul;
    logic                      branch_taken_e;
    logic                      pcsrc_w;
    logic                      stall_f;
    logic                      stall_d;
    logic                      stall_e;
    logic                      flush_d;
    logic                      flush_e;
    logic                      bubble_m;
    logic [NUM_SRC*2-1:0]      fwd_sel_e;
    logic [NUM_SRC-1:0]        fwd_hi_e;
    logic                      mul_busy;

    modport master (
        output d_valid, d_src_addr, d_src_used, d_dst_addr, d_dst2_addr,
               d_dst_we, d_dst2_we, d_is_load, d_is_mul, branch_taken_e, pcsrc_w,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m,
               fwd_sel_e, fwd_hi_e, mul_busy
    );

    modport slave (
        input  d_valid, d_src_addr, d_src_used, d_dst_addr, d_dst2_addr,
               d_dst_we, d_dst2_we, d_is_load, d_is_mul, branch_taken_e, pcsrc_w,
        output stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m,
               fwd_sel_e, fwd_hi_e, mul_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller for a 5-stage F/D/E/M/W pipeline.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    hazard_scoreboard_if slave: D instruction fields, branch/PC-write
//          inputs, stall/flush/bubble controls, forwarding selects, mul_busy
// Tracks destination tags for E/M/W (two destinations per instruction for long
// multiply) and a multiply occupancy counter; all outputs are combinational
// from that state and the D inputs.
module hazard_scoreboard #(
    parameter int REG_AW      = 4,
    parameter int NUM_SRC     = 3,
    parameter int MUL_LATENCY = 4,
    parameter int PC_REG      = 15
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam int CW = $clog2(MUL_LATENCY) + 1;
    localparam logic [REG_AW-1:0] PC = REG_AW'(PC_REG);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] dst2;
        logic              we;
        logic              we2;
    } tag_t;

    tag_t                      e_q, m_q, w_q, e_d, d_tag;
    logic                      e_load_q, m_load_q, e_load_d;
    logic [NUM_SRC*REG_AW-1:0] e_src_q, e_src_d;
    logic [NUM_SRC-1:0]        e_used_q, e_used_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [NUM_SRC-1:0]        fwd_hi, lu_hit;
    logic                      busy, lu, pcw, br, lu_stall, flush_d, flush_e, load_mul;

    // {matched via dst2, matched via dst}; the PC alias never matches
    function automatic logic [1:0] hit(input tag_t t, input logic [REG_AW-1:0] r);
        return {t.valid & t.we2 & (t.dst2 == r) & (r != PC),
                t.valid & t.we  & (t.dst  == r) & (r != PC)};
    endfunction

    // M beats W; a load in M has no data yet, so it falls through to W.
    // The high half is chosen only when dst2 matched and dst did not.
    always_comb begin
        fwd_sel = '0;
        fwd_hi  = '0;
        lu_hit  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (e_used_q[i] && |hit(m_q, e_src_q[i*REG_AW +: REG_AW]) && !m_load_q) begin
                fwd_sel[2*i +: 2] = 2'b10;
                fwd_hi[i]         = hit(m_q, e_src_q[i*REG_AW +: REG_AW]) == 2'b10;
            end else if (e_used_q[i] && |hit(w_q, e_src_q[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b01;
                fwd_hi[i]         = hit(w_q, e_src_q[i*REG_AW +: REG_AW]) == 2'b10;
            end
            lu_hit[i] = bus.d_src_used[i] & |hit(e_q, bus.d_src_addr[i*REG_AW +: REG_AW]);
        end
    end

    assign busy     = cnt_q != '0;
    assign lu       = bus.d_valid & e_load_q & |lu_hit;
    assign pcw      = (bus.d_valid & bus.d_dst_we & (bus.d_dst_addr == PC))
                    | (e_q.valid & e_q.we & (e_q.dst == PC))
                    | (m_q.valid & m_q.we & (m_q.dst == PC));
    // a branch sitting behind an unfinished multiply is not yet resolved
    assign br       = bus.branch_taken_e & e_q.valid & ~busy;
    assign lu_stall = lu & ~br;
    assign flush_d  = br | pcw | bus.pcsrc_w;
    // a held E cannot also be cleared
    assign flush_e  = (lu | br) & ~busy;

    assign bus.stall_f   = lu_stall | pcw | busy;
    assign bus.stall_d   = (lu_stall | busy) & ~flush_d;
    assign bus.stall_e   = busy;
    assign bus.flush_d   = flush_d;
    assign bus.flush_e   = flush_e;
    assign bus.bubble_m  = busy;
    assign bus.mul_busy  = busy;
    assign bus.fwd_sel_e = fwd_sel;
    assign bus.fwd_hi_e  = fwd_hi;

    always_comb begin
        d_tag    = '{valid: 1'b1, dst: bus.d_dst_addr, dst2: bus.d_dst2_addr,
                     we: bus.d_dst_we, we2: bus.d_dst2_we};
        e_d      = busy ? e_q : (flush_e | ~bus.d_valid) ? '0 : d_tag;
        e_load_d = busy ? e_load_q : ~flush_e & bus.d_valid & bus.d_is_load;
        e_src_d  = busy ? e_src_q : (flush_e | ~bus.d_valid) ? '0 : bus.d_src_addr;
        e_used_d = busy ? e_used_q : (flush_e | ~bus.d_valid) ? '0 : bus.d_src_used;
        load_mul = ~busy & ~flush_e & bus.d_valid & bus.d_is_mul;
        cnt_d    = busy ? cnt_q - CW'(1) : load_mul ? CW'(MUL_LATENCY - 1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            e_load_q <= 1'b0;
            m_load_q <= 1'b0;
            e_src_q  <= '0;
            e_used_q <= '0;
            cnt_q    <= '0;
        end else begin
            e_q      <= e_d;
            e_load_q <= e_load_d;
            e_src_q  <= e_src_d;
            e_used_q <= e_used_d;
            m_q      <= busy ? '0 : e_q;
            m_load_q <= ~busy & e_load_q;
            w_q      <= m_q;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked against
// an instruction-level pipeline model of the hazard rules.
module tb_hazard_scoreboard;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(4), .NUM_SRC(3)) bus ();
    hazard_scoreboard #(.REG_AW(4), .NUM_SRC(3), .MUL_LATENCY(LAT), .PC_REG(15))
        dut (.clk(clk), .reset(reset), .bus(bus));

    // {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, mul_busy}
    logic [6:0] ctl;
    assign ctl = {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e,
                  bus.bubble_m, bus.mul_busy};

    typedef struct packed {
        logic        v;
        logic [11:0] src;
        logic [2:0]  used;
        logic [3:0]  dst, dst2;
        logic        we, we2, ld;
    } ins_t;

    typedef struct packed {
        logic [6:0] ctl;
        logic [5:0] sel;
        logic [2:0] hi;
    } exp_t;

    ins_t me = '0, mm = '0, mw = '0;
    int mul_left = 0;
    int vectors = 0, errors = 0;

    function automatic logic wr(ins_t t, logic [3:0] r);
        return t.v && r != 4'd15 && ((t.we && t.dst == r) || (t.we2 && t.dst2 == r));
    endfunction

    function automatic exp_t model();
        exp_t x;
        logic lu, pcw, br, busy, fd;
        x = '0;
        lu = 1'b0;
        busy = mul_left > 0;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] s;
            logic [3:0] ds;
            s = me.src[i*4 +: 4];
            ds = bus.d_src_addr[i*4 +: 4];
            if (me.used[i]) begin
                if (wr(mm, s) && !mm.ld) begin
                    x.sel[2*i +: 2] = 2'b10;
                    x.hi[i] = !(mm.we && mm.dst == s);
                end else if (wr(mw, s)) begin
                    x.sel[2*i +: 2] = 2'b01;
                    x.hi[i] = !(mw.we && mw.dst == s);
                end
            end
            if (bus.d_valid && bus.d_src_used[i] && me.ld && wr(me, ds)) lu = 1'b1;
        end
        pcw = (bus.d_valid && bus.d_dst_we && bus.d_dst_addr == 4'd15) ||
              (me.v && me.we && me.dst == 4'd15) || (mm.v && mm.we && mm.dst == 4'd15);
        br = bus.branch_taken_e && me.v && !busy;
        fd = br || pcw || bus.pcsrc_w;
        x.ctl = {(lu && !br) || pcw || busy, ((lu && !br) || busy) && !fd, busy, fd,
                 (lu || br) && !busy, busy, busy};
        return x;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            me <= '0;
            mm <= '0;
            mw <= '0;
            mul_left <= 0;
        end else begin
            exp_t x;
            ins_t din;
            x = model();
            din = '{v: 1'b1, src: bus.d_src_addr, used: bus.d_src_used, dst: bus.d_dst_addr,
                    dst2: bus.d_dst2_addr, we: bus.d_dst_we, we2: bus.d_dst2_we, ld: bus.d_is_load};
            mw <= mm;
            mm <= x.ctl[4] ? '0 : me;
            me <= x.ctl[4] ? me : (x.ctl[2] || !bus.d_valid) ? '0 : din;
            mul_left <= mul_left > 0 ? mul_left - 1 :
                        (!x.ctl[2] && bus.d_valid && bus.d_is_mul) ? LAT - 1 : 0;
        end
    end

    task automatic idle();
        bus.d_valid = 0; bus.d_src_addr = 0; bus.d_src_used = 0; bus.d_dst_addr = 0;
        bus.d_dst2_addr = 0; bus.d_dst_we = 0; bus.d_dst2_we = 0; bus.d_is_load = 0;
        bus.d_is_mul = 0; bus.branch_taken_e = 0; bus.pcsrc_w = 0;
    endtask

    task automatic set_d(logic [11:0] src, logic [2:0] used, logic [3:0] dst, logic [3:0] dst2,
                         logic we, logic we2, logic ld, logic mul);
        bus.d_valid = 1; bus.d_src_addr = src; bus.d_src_used = used; bus.d_dst_addr = dst;
        bus.d_dst2_addr = dst2; bus.d_dst_we = we; bus.d_dst2_we = we2; bus.d_is_load = ld;
        bus.d_is_mul = mul;
    endtask

    task automatic drain();
        idle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 0;
        #2;
        vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 7'b0); end
        vectors++; if (bus.fwd_sel_e !== 6'b0) begin errors++; $display("FAIL reset_sel got %b exp 000000", bus.fwd_sel_e); end
        vectors++; if (bus.fwd_hi_e !== 3'b0) begin errors++; $display("FAIL reset_hi got %b exp 000", bus.fwd_hi_e); end
        @(negedge clk) reset = 1;
    endtask

    task automatic test_forward();
        set_d(12'h000, 3'b000, 4'd3, 4'd0, 1, 0, 0, 0);
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL fwd_add_ctl got %b exp 0", ctl); end
        @(negedge clk) set_d(12'h003, 3'b001, 4'd0, 4'd0, 0, 0, 0, 0);
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL fwd_cons_ctl got %b exp 0", ctl); end
        @(negedge clk);
        #1 vectors++; if (bus.fwd_sel_e[1:0] !== 2'b10) begin errors++; $display("FAIL fwd_m_sel got %b exp 10", bus.fwd_sel_e[1:0]); end
        vectors++; if (bus.fwd_hi_e[0] !== 1'b0) begin errors++; $display("FAIL fwd_m_hi got %b exp 0", bus.fwd_hi_e[0]); end
        @(negedge clk) idle();
        #1 vectors++; if (bus.fwd_sel_e[1:0] !== 2'b01) begin errors++; $display("FAIL fwd_w_sel got %b exp 01", bus.fwd_sel_e[1:0]); end
        drain();
    endtask

    task automatic test_load_use();
        set_d(12'h000, 3'b000, 4'd5, 4'd0, 1, 0, 1, 0);
        #1;
        @(negedge clk) set_d(12'h050, 3'b010, 4'd0, 4'd0, 0, 0, 0, 0);
        #1 vectors++; if (ctl !== 7'b1100100) begin errors++; $display("FAIL lu_stall got %b exp 1100100", ctl); end
        @(negedge clk);
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL lu_release got %b exp 0", ctl); end
        @(negedge clk) idle();
        #1 vectors++; if (bus.fwd_sel_e[3:2] !== 2'b01) begin errors++; $display("FAIL lu_fwd_sel got %b exp 01", bus.fwd_sel_e[3:2]); end
        vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL lu_after_ctl got %b exp 0", ctl); end
        drain();
    endtask

    task automatic test_mul();
        set_d(12'h000, 3'b000, 4'd2, 4'd7, 1, 1, 0, 1);
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL mul_issue got %b exp 0", ctl); end
        @(negedge clk) set_d(12'h700, 3'b100, 4'd0, 4'd0, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            #1 vectors++; if (ctl !== 7'b1110011) begin errors++; $display("FAIL mul_busy_c%0d got %b exp 1110011", c, ctl); end
            @(negedge clk);
        end
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL mul_done got %b exp 0", ctl); end
        @(negedge clk) idle();
        #1 vectors++; if (bus.fwd_sel_e[5:4] !== 2'b10) begin errors++; $display("FAIL mul_fwd_sel got %b exp 10", bus.fwd_sel_e[5:4]); end
        vectors++; if (bus.fwd_hi_e[2] !== 1'b1) begin errors++; $display("FAIL mul_fwd_hi got %b exp 1", bus.fwd_hi_e[2]); end
        drain();
    endtask

    task automatic test_branch();
        set_d(12'h000, 3'b000, 4'd5, 4'd0, 1, 0, 1, 0);
        #1;
        @(negedge clk) set_d(12'h050, 3'b010, 4'd0, 4'd0, 0, 0, 0, 0);
        bus.branch_taken_e = 1;
        #1 vectors++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL br_over_lu got %b exp 0001100", ctl); end
        @(negedge clk) drain();
        set_d(12'h000, 3'b000, 4'd0, 4'd0, 0, 0, 0, 1);
        #1;
        @(negedge clk) idle();
        bus.branch_taken_e = 1;
        #1 vectors++; if (ctl !== 7'b1110011) begin errors++; $display("FAIL br_during_mul got %b exp 1110011", ctl); end
        @(negedge clk) drain();
    endtask

    task automatic test_pc_write();
        set_d(12'h000, 3'b000, 4'd15, 4'd0, 1, 0, 0, 0);
        #1 vectors++; if (ctl !== 7'b1001000) begin errors++; $display("FAIL pcw_d got %b exp 1001000", ctl); end
        @(negedge clk) set_d(12'h00f, 3'b001, 4'd0, 4'd0, 0, 0, 0, 0);
        #1 vectors++; if (ctl !== 7'b1001000) begin errors++; $display("FAIL pcw_e got %b exp 1001000", ctl); end
        @(negedge clk) idle();
        #1 vectors++; if (ctl !== 7'b1001000) begin errors++; $display("FAIL pcw_m got %b exp 1001000", ctl); end
        vectors++; if (bus.fwd_sel_e[1:0] !== 2'b00) begin errors++; $display("FAIL pcw_no_fwd got %b exp 00", bus.fwd_sel_e[1:0]); end
        @(negedge clk);
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL pcw_w got %b exp 0", ctl); end
        bus.pcsrc_w = 1;
        #1 vectors++; if (ctl !== 7'b0001000) begin errors++; $display("FAIL pcsrc_w got %b exp 0001000", ctl); end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        set_d(12'h000, 3'b000, 4'd2, 4'd0, 1, 0, 0, 1);
        #1;
        @(negedge clk) idle();
        @(negedge clk);
        #1 vectors++; if (ctl !== 7'b1110011) begin errors++; $display("FAIL rmul_busy got %b exp 1110011", ctl); end
        #1 reset = 0;
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL rmul_async got %b exp 0", ctl); end
        vectors++; if ({bus.fwd_sel_e, bus.fwd_hi_e} !== 9'b0) begin errors++; $display("FAIL rmul_fwd got %b exp 0", {bus.fwd_sel_e, bus.fwd_hi_e}); end
        @(negedge clk) reset = 1;
        #1;
        @(negedge clk);
        #1 vectors++; if (ctl !== 7'b0) begin errors++; $display("FAIL rmul_residual got %b exp 0", ctl); end
        drain();
    endtask

    function automatic logic [3:0] pick();
        int r;
        r = $urandom_range(0, 8);
        return r == 8 ? 4'd15 : 4'(r);
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            exp_t x;
            int kind;
            @(negedge clk);
            kind = $urandom_range(0, 5);
            bus.d_valid = $urandom_range(0, 3) != 0;
            bus.d_src_addr = {pick(), pick(), pick()};
            bus.d_src_used = 3'($urandom);
            bus.d_dst_addr = pick();
            bus.d_dst2_addr = pick();
            bus.d_is_load = bus.d_valid && kind == 0;
            bus.d_is_mul = bus.d_valid && kind == 1;
            bus.d_dst_we = bus.d_valid && $urandom_range(0, 3) != 0;
            bus.d_dst2_we = bus.d_is_mul && $urandom_range(0, 1) == 1;
            bus.branch_taken_e = $urandom_range(0, 7) == 0;
            bus.pcsrc_w = $urandom_range(0, 15) == 0;
            #1 x = model();
            vectors++; if (ctl !== x.ctl) begin errors++; $display("FAIL rnd_ctl n=%0d got %b exp %b", n, ctl, x.ctl); end
            vectors++; if (bus.fwd_sel_e !== x.sel) begin errors++; $display("FAIL rnd_sel n=%0d got %b exp %b", n, bus.fwd_sel_e, x.sel); end
            vectors++; if (bus.fwd_hi_e !== x.hi) begin errors++; $display("FAIL rnd_hi n=%0d got %b exp %b", n, bus.fwd_hi_e, x.hi); end
        end
        drain();
    endtask

    initial begin
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_mul();
        test_branch();
        test_pc_write();
        test_reset_mid_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (F/D/E/M/W).
- Keeps its own destination-tag pipeline (E/M/W) and supports dual-destination instructions (long multiply: low word to dst, high word to dst2).
- Generates per-source forwarding selects, load-use and multi-cycle-multiply stalls, branch/PC-write flushes, and bubble controls for the datapath pipeline registers.

Parameters:
- REG_AW, 4: register address width.
- NUM_SRC, 3: source operands tracked per instruction.
- MUL_LATENCY, 4: cycles a multiply occupies E (>=1; 1 means no extra stall).
- PC_REG, 15: register index that aliases the PC; never forwarded.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- d_valid  in  1  D holds a real instruction.
- d_src_addr  in  NUM_SRC*REG_AW  D source addresses; src i = bits [i*REG_AW +: REG_AW].
- d_src_used  in  NUM_SRC  per-source "operand is read" flag.
- d_dst_addr, d_dst2_addr  in  REG_AW each  D destination addresses (low, high).
- d_dst_we, d_dst2_we  in  1 each  destination write enables.
- d_is_load, d_is_mul  in  1 each  D instruction class.
- branch_taken_e  in  1  branch resolved taken in E.
- pcsrc_w  in  1  W writes PC.
- stall_f, stall_d, stall_e  out  1  hold the F, D and E pipeline registers.
- flush_d, flush_e  out  1  clear the D and E registers (bubble).
- bubble_m  out  1  load a bubble into the M register.
- fwd_sel_e  out  NUM_SRC*2  per source: 00 register file, 01 ResultW, 10 ALUOutM.
- fwd_hi_e  out  NUM_SRC  select the upper 32 bits of the forwarded 64-bit result.
- mul_busy  out  1  multiply counter is non-zero.

Behaviour:
- Internal state: tags for E, M and W. Each tag holds valid, dst, dst2, we, we2 and is_load. E also holds the source addresses and used flags. Plus a mul counter cnt of width clog2(MUL_LATENCY)+1.
- Reset (reset=0, async): all tag valids 0, cnt=0.
  - Consequently every output is 0, fwd_sel_e = 0 and fwd_hi_e = 0.
  - Reset mid-multiply aborts the multiply.
- Outputs are combinational from the registered state and the D inputs. State updates on the rising clk edge.
- A tag "writes r" when: valid & ((we & dst==r) | (we2 & dst2==r)) & r != PC_REG.
- Forwarding, per E source i with used_i:
  - M writes src: sel=10, unless M.is_load, in which case fall through to W.
  - Otherwise W writes src: sel=01.
  - Otherwise sel=00.
  - fwd_hi_e[i] = 1 when the chosen stage matched via dst2 and not via dst; dst wins when dst==dst2.
  - M has priority over W.
- Load-use (lu): d_valid and any used D source written by E with E.is_load.
  - Effect: stall_f=stall_d=1, flush_e=1.
- PC-write pending (pcw): any of D, E or M has we & dst==PC_REG.
  - Effect: stall_f=1, flush_d=1.
  - pcsrc_w=1 also forces flush_d=1.
- Multiply:
  - When a D instruction with d_is_mul transfers into E (not stalled, not flushed), cnt <= MUL_LATENCY-1.
  - While cnt != 0: stall_f=stall_d=stall_e=1, bubble_m=1, cnt decrements each cycle, mul_busy=1.
  - The multiply therefore occupies E for exactly MUL_LATENCY cycles.
- Branch:
  - branch_taken_e is honoured only when E.valid & cnt==0.
  - Effect: flush_d=flush_e=1, and the lu-induced stall_f/stall_d are suppressed that cycle.
- Priorities: flush_d overrides stall_d; flush_e overrides the D->E transfer; stall_e overrides flush_e (E is held, not cleared).
- Tag advance per edge:
  - W <= M.
  - M <= bubble when stall_e, else E.
  - E <= held when stall_e; else bubble when flush_e or !d_valid; else the D fields.

Test Plan:
- E: ADD writing r3 (we=1); next D uses r3 as src0 -> one cycle later src0 fwd_sel_e=10, fwd_hi_e[0]=0; the following cycle a consumer of r3 gets 01.
- LDR r5 in E; D src1=r5 used -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; next cycle src1 fwd_sel_e=01, no stall.
- MUL (MUL_LATENCY=4, dst=r2, dst2=r7) enters E -> stall_e/bubble_m/mul_busy=1 for 3 cycles, then 0; consumer of r7 sees fwd_sel=10 with fwd_hi=1.
- branch_taken_e=1 while lu is true -> flush_d=flush_e=1, stall_f=stall_d=0; branch_taken_e while mul_busy -> ignored.
- D writes r15 -> stall_f=flush_d=1 on each cycle it sits in D, E or M (3 cycles); r15 sources always get fwd_sel=00.
- reset driven low during cycle 2 of a multiply -> mul_busy, stalls and fwd outputs go 0 immediately (asynchronously); after release, no residual stall.
